load_unit_ctrl: RTL
===================

# load_unit_ctrl

Sequencer for the RV64I data-memory load path in the MEM stage. It accepts one load at a time from the pipeline and issues one or two aligned 64-bit reads to the data memory. It then extracts, sign-extends or zero-extends the result with func3 load semantics and returns a single write-back beat. It owns the memory request handshake, split handling for misaligned loads, and flush recovery.

## Interface
- No parameters; address and data paths are fixed at 64 bits.
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- ld_valid  in  1  load request from pipeline
- ld_ready  out  1  controller idle, can accept a request
- ld_addr  in  64  byte address
- ld_func3  in  3  load type: 000 LB, 001 LH, 010 LW, 011 LD, 100 LBU, 101 LHU, 110 LWU, 111 illegal
- ld_rd  in  5  destination register tag
- flush  in  1  abort the in-flight load
- mem_req  out  1  memory read request, held until granted
- mem_addr  out  64  8-byte-aligned address, bits [2:0] always 0
- mem_gnt  in  1  request accepted this cycle
- mem_rvalid  in  1  read data valid, at least 1 cycle after gnt, one outstanding
- mem_rdata  in  64  read data
- wb_valid  out  1  one-cycle result pulse
- wb_rd  out  5  captured ld_rd
- wb_data  out  64  extended load result
- ld_misaligned  out  1  one-cycle exception pulse (configuration dependent)

## Operation
- Request capture:
  - Handshake is ld_valid && ld_ready.
  - On handshake, register addr, func3 and rd.
  - offset = addr[2:0].
  - size = 1, 2, 4 or 8 bytes, from func3[1:0].
  - split = (offset + size > 8).
- States:
  - IDLE: ld_ready=1.
    - Handshake with func3=111 → RESP with data 0 and no memory access.
    - Otherwise → REQ0.
  - REQ0: mem_req=1, mem_addr = {addr[63:3], 3'b0}. mem_gnt → WAIT0.
  - WAIT0: mem_rvalid → capture beat0.
    - If split → REQ1.
    - Otherwise → RESP.
  - REQ1: mem_req=1, mem_addr = previous mem_addr + 8, wrapping modulo 2^64. mem_gnt → WAIT1.
  - WAIT1: mem_rvalid → capture beat1, → RESP.
  - RESP: wb_valid=1 for exactly one cycle, → IDLE.
  - DRAIN: wait for the pending mem_rvalid, discard it, → IDLE. No wb_valid.
- Extraction:
  - Take the low 64 bits of ({beat1, beat0} >> (offset*8)).
  - beat1 = 0 when the load is not split.
  - Extend per func3: sign-extend for 000/001/010, zero-extend for 100/101/110, pass through for 011.
- Flush: when asserted, flush has priority over every other event in the same cycle.
  - In REQ0 or REQ1 without mem_gnt in the same cycle: → IDLE, and mem_req drops next cycle.
  - In REQ0 or REQ1 with mem_gnt in the same cycle, or in WAIT0 or WAIT1 without mem_rvalid: → DRAIN.
  - In WAIT0 or WAIT1 with mem_rvalid in the same cycle, or in RESP: → IDLE. wb_valid is suppressed in that cycle.
  - In IDLE: blocks the handshake (ld_ready=0 while flush=1).
- mem_rvalid outside WAIT*/DRAIN is a protocol error and is ignored.

## Timing
- Reset: state=IDLE, ld_ready=1, mem_req=0, mem_addr=0, wb_valid=0, wb_rd=0, wb_data=0, ld_misaligned=0.
- Reset mid-operation returns to IDLE immediately. Any memory response still outstanding is the memory's responsibility to drop.
- Non-split load, with gnt in the request cycle and rvalid one cycle later:
  - handshake at cycle T
  - mem_req at T+1
  - rvalid at T+2
  - wb_valid at T+3
- Split load adds 2 cycles: wb_valid at T+5.
- func3=111: wb_valid at T+1.
- mem_req and mem_addr are registered and stable until mem_gnt.
- wb_data and wb_rd are registered; they hold their value after the wb_valid pulse until the next result.
- Back-to-back throughput: a new handshake is possible in the cycle after RESP.

## Configuration
- MISALIGN_SPLIT_EN defined: split loads take the REQ1/WAIT1 path as described.
- MISALIGN_SPLIT_EN undefined:
  - A load with split=1 issues no memory access and skips REQ1/WAIT1 logic.
  - ld_misaligned pulses at T+1 and the controller returns to IDLE at T+1.
  - No wb_valid is produced.
  - The split path must synthesize away.

## Test plan
- LD, addr=0x1000, rdata=0x8877665544332211 → mem_addr=0x1000, wb_data=0x8877665544332211, wb_valid at T+3.
- LB, addr=0x1007, rdata=0x80xx…xx → wb_data=0xFFFFFFFFFFFFFF80. Same with LBU → wb_data=0x0000000000000080.
- LW, addr=0x1006, beat0=0xBBAA000000000000, beat1=0x…00000000000000DDCC; with MISALIGN_SPLIT_EN:
  - mem_addr 0x1000, then 0x1008.
  - wb_data=0xFFFFFFFFDDCCBBAA at T+5.
  - Without the macro: ld_misaligned at T+1 and no mem_req.
- Delayed grant: mem_gnt held low 4 cycles → mem_req and mem_addr stable throughout; wb_valid 4 cycles later than nominal.
- Flush in WAIT0 → DRAIN; the following rvalid is discarded, there is no wb_valid, and ld_ready returns the cycle after.
- func3=111 → no mem_req; wb_valid at T+1 with wb_data=0. A flush asserted in RESP suppresses the pulse.

Source files
------------

// File: rtl/load_unit_ctrl.sv
// RV64I MEM-stage load sequencer: one or two aligned 64-bit reads, byte extraction and extension.
// Define MISALIGN_SPLIT_EN to service loads crossing an 8-byte boundary; otherwise they raise ld_misaligned.
module load_unit_ctrl (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ld_valid,
    output logic        ld_ready,
    input  logic [63:0] ld_addr,
    input  logic [2:0]  ld_func3,
    input  logic [4:0]  ld_rd,
    input  logic        flush,
    output logic        mem_req,
    output logic [63:0] mem_addr,
    input  logic        mem_gnt,
    input  logic        mem_rvalid,
    input  logic [63:0] mem_rdata,
    output logic        wb_valid,
    output logic [4:0]  wb_rd,
    output logic [63:0] wb_data,
    output logic        ld_misaligned
);

    localparam int unsigned XLEN = 64;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        REQ0  = 3'd1,
        WAIT0 = 3'd2,
        REQ1  = 3'd3,
        WAIT1 = 3'd4,
        RESP  = 3'd5,
        DRAIN = 3'd6
    } state_e;

    state_e            state_q, state_d;
    logic [2:0]        offset_q, offset_d;
    logic [2:0]        func3_q, func3_d;
    logic [4:0]        rd_q, rd_d;
    logic              mem_req_q, mem_req_d;
    logic [XLEN-1:0]   mem_addr_q, mem_addr_d;
    logic [XLEN-1:0]   wb_data_q, wb_data_d;
    logic [4:0]        wb_rd_q, wb_rd_d;
    logic              misaligned_q, misaligned_d;
    logic              hs_c;
    logic              split_c;
`ifdef MISALIGN_SPLIT_EN
    logic              split_q, split_d;
    logic [XLEN-1:0]   beat0_q, beat0_d;
`endif

    // Shift the two-beat window down to the addressed byte, then extend per func3.
    function automatic logic [XLEN-1:0] extract(input logic [XLEN-1:0] b1,
                                                input logic [XLEN-1:0] b0,
                                                input logic [2:0]      off,
                                                input logic [2:0]      f3);
        logic [XLEN-1:0] raw;
        logic [XLEN-1:0] res;
        raw = XLEN'({b1, b0} >> {off, 3'b000});
        case (f3)
            3'b000:  res = {{56{raw[7]}},  raw[7:0]};
            3'b001:  res = {{48{raw[15]}}, raw[15:0]};
            3'b010:  res = {{32{raw[31]}}, raw[31:0]};
            3'b011:  res = raw;
            3'b100:  res = {56'd0, raw[7:0]};
            3'b101:  res = {48'd0, raw[15:0]};
            3'b110:  res = {32'd0, raw[31:0]};
            default: res = '0;
        endcase
        return res;
    endfunction

    assign hs_c    = (state_q == IDLE) && ld_valid && !flush;
    assign split_c = (5'(ld_addr[2:0]) + (5'd1 << ld_func3[1:0])) > 5'd8;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            offset_q     <= '0;
            func3_q      <= '0;
            rd_q         <= '0;
            mem_req_q    <= 1'b0;
            mem_addr_q   <= '0;
            wb_data_q    <= '0;
            wb_rd_q      <= '0;
            misaligned_q <= 1'b0;
`ifdef MISALIGN_SPLIT_EN
            split_q      <= 1'b0;
            beat0_q      <= '0;
`endif
        end else begin
            state_q      <= state_d;
            offset_q     <= offset_d;
            func3_q      <= func3_d;
            rd_q         <= rd_d;
            mem_req_q    <= mem_req_d;
            mem_addr_q   <= mem_addr_d;
            wb_data_q    <= wb_data_d;
            wb_rd_q      <= wb_rd_d;
            misaligned_q <= misaligned_d;
`ifdef MISALIGN_SPLIT_EN
            split_q      <= split_d;
            beat0_q      <= beat0_d;
`endif
        end
    end

    // Next state and datapath; flush is checked before every other event.
    always_comb begin
        state_d      = state_q;
        offset_d     = offset_q;
        func3_d      = func3_q;
        rd_d         = rd_q;
        mem_addr_d   = mem_addr_q;
        wb_data_d    = wb_data_q;
        wb_rd_d      = wb_rd_q;
        misaligned_d = 1'b0;
`ifdef MISALIGN_SPLIT_EN
        split_d      = split_q;
        beat0_d      = beat0_q;
`endif
        case (state_q)
            IDLE: begin
                if (hs_c) begin
                    offset_d = ld_addr[2:0];
                    func3_d  = ld_func3;
                    rd_d     = ld_rd;
`ifdef MISALIGN_SPLIT_EN
                    split_d  = split_c;
                    if (ld_func3 == 3'b111) begin
                        state_d   = RESP;
                        wb_data_d = '0;
                        wb_rd_d   = ld_rd;
                    end else begin
                        state_d    = REQ0;
                        mem_addr_d = {ld_addr[63:3], 3'b000};
                    end
`else
                    if (ld_func3 == 3'b111) begin
                        state_d   = RESP;
                        wb_data_d = '0;
                        wb_rd_d   = ld_rd;
                    end else if (split_c) begin
                        misaligned_d = 1'b1;
                    end else begin
                        state_d    = REQ0;
                        mem_addr_d = {ld_addr[63:3], 3'b000};
                    end
`endif
                end
            end
            REQ0: begin
                if (flush)        state_d = mem_gnt ? DRAIN : IDLE;
                else if (mem_gnt) state_d = WAIT0;
            end
            WAIT0: begin
                if (flush) begin
                    state_d = mem_rvalid ? IDLE : DRAIN;
                end else if (mem_rvalid) begin
`ifdef MISALIGN_SPLIT_EN
                    if (split_q) begin
                        beat0_d    = mem_rdata;
                        state_d    = REQ1;
                        mem_addr_d = mem_addr_q + 64'd8;
                    end else begin
                        state_d   = RESP;
                        wb_data_d = extract('0, mem_rdata, offset_q, func3_q);
                        wb_rd_d   = rd_q;
                    end
`else
                    state_d   = RESP;
                    wb_data_d = extract('0, mem_rdata, offset_q, func3_q);
                    wb_rd_d   = rd_q;
`endif
                end
            end
`ifdef MISALIGN_SPLIT_EN
            REQ1: begin
                if (flush)        state_d = mem_gnt ? DRAIN : IDLE;
                else if (mem_gnt) state_d = WAIT1;
            end
            WAIT1: begin
                if (flush) begin
                    state_d = mem_rvalid ? IDLE : DRAIN;
                end else if (mem_rvalid) begin
                    state_d   = RESP;
                    wb_data_d = extract(mem_rdata, beat0_q, offset_q, func3_q);
                    wb_rd_d   = rd_q;
                end
            end
`endif
            RESP:    state_d = IDLE;
            DRAIN: begin
                if (mem_rvalid) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        mem_req_d = (state_d == REQ0) || (state_d == REQ1);
    end

    assign ld_ready      = (state_q == IDLE) && !flush;
    assign wb_valid      = (state_q == RESP) && !flush;
    assign mem_req       = mem_req_q;
    assign mem_addr      = mem_addr_q;
    assign wb_rd         = wb_rd_q;
    assign wb_data       = wb_data_q;
    assign ld_misaligned = misaligned_q;

endmodule
